jt12_wrq: RTL and testbench

JT12_WRQ -- requirements
Module: jt12_wrq

---
 rtl/jt12_wrq_pkg.sv | 29 ++
 rtl/jt12_wrq_fifo.sv | 61 ++++++
 rtl/jt12_wrq.sv | 169 ++++++++++++++++
 tb/tb_jt12_wrq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wrq_pkg.sv
// Shared types and entry layout for the jt12 write queue.
// The entry is {port, reg, data}; the FSM state enum lives here so the bench and RTL agree.
package jt12_wrq_pkg;

    localparam int ENTRY_W  = 17;
    localparam int PORT_BIT = 16;
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AWR,
        ST_AGAP,
        ST_DWR,
        ST_SETTLE,
        ST_BWAIT
    } state_t;

    // Width of a down-counter that is loaded with (max of the three limits) - 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/jt12_wrq_fifo.sv
// Synchronous FIFO holding queued chip writes; DEPTH must be a power of two.
module jt12_wrq_fifo
    import jt12_wrq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/jt12_wrq.sv
// Host-side write queue for the jt12 core: FIFO plus an address/data/busy-poll sequencer.
// Optional busy-wait timeout is enabled with JT12_WRQ_TIMEOUT_EN.
//
//   state     | meaning
//   IDLE      | wait for a queued entry, pop it on a cen pulse
//   AWR       | address write, cs_n/wr_n low
//   AGAP      | one cen pulse with cs_n/wr_n high
//   DWR       | data write, cs_n/wr_n low
//   SETTLE    | let the chip raise busy before polling it
//   BWAIT     | poll chip_dout[7] until it reads 0
module jt12_wrq
    import jt12_wrq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int WR_HOLD = 2,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cen,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_port,
    input  logic [7:0]              req_reg,
    input  logic [7:0]              req_data,
    output logic [1:0]              chip_addr,
    output logic [7:0]              chip_din,
    output logic                    chip_cs_n,
    output logic                    chip_wr_n,
    input  logic [7:0]              chip_dout,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    idle,
    output logic                    timeout_err
);

    localparam int CW = cnt_width(WR_HOLD, SETTLE, TIMEOUT);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [8:0]           hold_q;
    logic [1:0]           addr_q;
    logic [7:0]           din_q;
    logic                 cs_n_q;
    logic                 wr_n_q;
    logic [ENTRY_W-1:0]   head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 unused_dout;

    assign unused_dout = ^chip_dout[6:0];

    assign req_ready = ~rst & ~fifo_full;
    assign push      = req_valid & req_ready;
    assign pop       = (state_q == ST_IDLE) & cen & ~fifo_empty;

    jt12_wrq_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({req_port, req_reg, req_data}),
        .dout_o  (head),
        .level_o (level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef JT12_WRQ_TIMEOUT_EN
    logic err_q;
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
`ifdef JT12_WRQ_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else if (cen) begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        hold_q  <= {head[PORT_BIT], head[DATA_MSB:0]};
                        addr_q  <= {head[PORT_BIT], 1'b0};
                        din_q   <= head[REG_MSB:REG_LSB];
                        cs_n_q  <= 1'b0;
                        wr_n_q  <= 1'b0;
                        cnt_q   <= CW'(WR_HOLD - 1);
                        state_q <= ST_AWR;
                    end
                end
                ST_AWR: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        state_q <= ST_AGAP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_AGAP: begin
                    addr_q  <= {hold_q[8], 1'b1};
                    din_q   <= hold_q[7:0];
                    cs_n_q  <= 1'b0;
                    wr_n_q  <= 1'b0;
                    cnt_q   <= CW'(WR_HOLD - 1);
                    state_q <= ST_DWR;
                end
                ST_DWR: begin
                    if (cnt_q == '0) begin
                        cs_n_q  <= 1'b1;
                        wr_n_q  <= 1'b1;
                        cnt_q   <= CW'(SETTLE - 1);
                        state_q <= ST_SETTLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= CW'(TIMEOUT - 1);
                        state_q <= ST_BWAIT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_BWAIT: begin
                    if (!chip_dout[7]) begin
                        state_q <= ST_IDLE;
                    end
`ifdef JT12_WRQ_TIMEOUT_EN
                    else if (cnt_q == '0) begin
                        err_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
`endif
                end
                default: begin
                    cs_n_q  <= 1'b1;
                    wr_n_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign chip_addr = addr_q;
    assign chip_din  = din_q;
    assign chip_cs_n = cs_n_q;
    assign chip_wr_n = wr_n_q;
    assign idle      = fifo_empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_jt12_wrq.sv
// Directed bench for jt12_wrq: write sequencing, bank select, full FIFO, cen gating, timeout, reset.
module tb_jt12_wrq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cen;
    logic       req_valid;
    logic       req_ready;
    logic       req_port;
    logic [7:0] req_reg;
    logic [7:0] req_data;
    logic [1:0] chip_addr;
    logic [7:0] chip_din;
    logic       chip_cs_n;
    logic       chip_wr_n;
    logic [7:0] chip_dout;
    logic [4:0] level;
    logic       idle;
    logic       timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jt12_wrq dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_port    (req_port),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .chip_addr   (chip_addr),
        .chip_din    (chip_din),
        .chip_cs_n   (chip_cs_n),
        .chip_wr_n   (chip_wr_n),
        .chip_dout   (chip_dout),
        .level       (level),
        .idle        (idle),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One push per clock, starting at the current negedge; returns after the last push edge.
    task automatic push_n(input int n, input logic p, input logic [7:0] r, input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b1;
            req_port  = p;
            req_reg   = r + 8'(i);
            req_data  = d;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int k;
        k = 0;
        while (!idle && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    initial begin
        int ph, lo1, gap, lo2;

        rst       = 1'b1;
        cen       = 1'b1;
        req_valid = 1'b0;
        req_port  = 1'b0;
        req_reg   = 8'h00;
        req_data  = 8'h00;
        chip_dout = 8'h00;
        step(3);

        chk("rst_cs_n",  32'(chip_cs_n), 32'd1);
        chk("rst_wr_n",  32'(chip_wr_n), 32'd1);
        chk("rst_addr",  32'(chip_addr), 32'd0);
        chk("rst_din",   32'(chip_din), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_err",   32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(1);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_idle",  32'(idle), 32'd1);

        // single write, cen always high, busy clear
        push_n(1, 1'b0, 8'h28, 8'hF0);
        chk("w1_level", 32'(level), 32'd1);
        chk("w1_idle",  32'(idle), 32'd0);
        step(1);
        chk("w1_awr_cs",   32'(chip_cs_n), 32'd0);
        chk("w1_awr_wr",   32'(chip_wr_n), 32'd0);
        chk("w1_awr_addr", 32'(chip_addr), 32'd0);
        chk("w1_awr_din",  32'(chip_din), 32'h28);
        chk("w1_pop_lvl",  32'(level), 32'd0);
        step(1);
        chk("w1_awr2_wr",  32'(chip_wr_n), 32'd0);
        step(1);
        chk("w1_gap_cs",   32'(chip_cs_n), 32'd1);
        chk("w1_gap_wr",   32'(chip_wr_n), 32'd1);
        chk("w1_gap_din",  32'(chip_din), 32'h28);
        step(1);
        chk("w1_dwr_cs",   32'(chip_cs_n), 32'd0);
        chk("w1_dwr_addr", 32'(chip_addr), 32'd1);
        chk("w1_dwr_din",  32'(chip_din), 32'hF0);
        step(1);
        chk("w1_dwr2_wr",  32'(chip_wr_n), 32'd0);
        step(1);
        chk("w1_set_cs",   32'(chip_cs_n), 32'd1);
        chk("w1_set_din",  32'(chip_din), 32'hF0);
        step(2);
        chk("w1_bwait_idle", 32'(idle), 32'd0);
        step(1);
        chk("w1_done_idle",  32'(idle), 32'd1);

        // bank select
        push_n(1, 1'b1, 8'hA4, 8'h22);
        step(1);
        chk("w2_awr_addr", 32'(chip_addr), 32'd2);
        chk("w2_awr_din",  32'(chip_din), 32'hA4);
        step(3);
        chk("w2_dwr_addr", 32'(chip_addr), 32'd3);
        chk("w2_dwr_din",  32'(chip_din), 32'h22);
        wait_idle("w2_idle", 20);

        // full FIFO with busy stuck high
        chip_dout = 8'h80;
        push_n(16, 1'b0, 8'h00, 8'h55);
        chk("full_lvl15",   32'(level), 32'd15);
        chk("full_rdy15",   32'(req_ready), 32'd1);
        push_n(1, 1'b0, 8'h10, 8'h55);
        chk("full_lvl16",   32'(level), 32'd16);
        chk("full_rdy16",   32'(req_ready), 32'd0);
        push_n(1, 1'b0, 8'h11, 8'h55);
        chk("full_drop_lvl", 32'(level), 32'd16);
        chk("full_idle",     32'(idle), 32'd0);
        chip_dout = 8'h00;
        wait_idle("full_drain", 400);
        chk("full_drain_lvl", 32'(level), 32'd0);

        // cen every 6th clock; push is independent of cen
        cen = 1'b0;
        push_n(1, 1'b0, 8'hB0, 8'h01);
        chk("cen_push_lvl", 32'(level), 32'd1);
        ph = 0; lo1 = 0; gap = 0; lo2 = 0;
        for (int k = 0; k < 150; k++) begin
            cen = ((k % 6) == 5);
            @(negedge clk);
            case (ph)
                0: if (!chip_wr_n) begin ph = 1; lo1 = 1; end
                1: if (!chip_wr_n) lo1++; else begin ph = 2; gap = 1; end
                2: if (chip_wr_n) gap++; else begin ph = 3; lo2 = 1; end
                3: if (!chip_wr_n) lo2++; else ph = 4;
                default: ;
            endcase
        end
        chk("cen_phase", 32'(ph), 32'd4);
        chk("cen_awr_len", 32'(lo1), 32'd12);
        chk("cen_gap_len", 32'(gap), 32'd6);
        chk("cen_dwr_len", 32'(lo2), 32'd12);
        cen = 1'b1;
        wait_idle("cen_idle", 40);

        // busy stuck high: timeout behaviour depends on build
        chip_dout = 8'h80;
        push_n(2, 1'b0, 8'hC0, 8'h02);
        step(261);
        chk("to_err_before", 32'(timeout_err), 32'd0);
        chk("to_busy_idle",  32'(idle), 32'd0);
        step(1);
`ifdef JT12_WRQ_TIMEOUT_EN
        chk("to_err_set", 32'(timeout_err), 32'd1);
        step(1);
        chk("to_next_cs",  32'(chip_cs_n), 32'd0);
        chk("to_next_lvl", 32'(level), 32'd0);
`else
        chk("to_err_tied", 32'(timeout_err), 32'd0);
        step(1);
        chk("to_stuck_cs",  32'(chip_cs_n), 32'd1);
        chk("to_stuck_lvl", 32'(level), 32'd1);
`endif
        chip_dout = 8'h00;
        rst = 1'b1;
        step(2);
        chk("to_rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step(1);

        // reset in the middle of the data write
        push_n(3, 1'b0, 8'h10, 8'h77);
        step(2);
        chk("mid_dwr_cs",   32'(chip_cs_n), 32'd0);
        chk("mid_dwr_addr", 32'(chip_addr), 32'd1);
        chk("mid_dwr_lvl",  32'(level), 32'd2);
        rst = 1'b1;
        step(1);
        chk("mid_rst_cs",  32'(chip_cs_n), 32'd1);
        chk("mid_rst_wr",  32'(chip_wr_n), 32'd1);
        chk("mid_rst_rdy", 32'(req_ready), 32'd0);
        rst = 1'b0;
        step(1);
        chk("mid_post_cs",   32'(chip_cs_n), 32'd1);
        chk("mid_post_wr",   32'(chip_wr_n), 32'd1);
        chk("mid_post_lvl",  32'(level), 32'd0);
        chk("mid_post_idle", 32'(idle), 32'd1);
        chk("mid_post_rdy",  32'(req_ready), 32'd1);
        step(10);
        chk("mid_quiet_cs",   32'(chip_cs_n), 32'd1);
        chk("mid_quiet_idle", 32'(idle), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
